// File: rtl/inst_fetch_buffer.sv
// +--------------------------------------------------------------------------+
// | inst_fetch_buffer: credit-limited prefetch FIFO between imem and decode.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module inst_fetch_buffer #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_resp_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_discard;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [INST_W-1:0]  r_inst_mem [DEPTH];
  logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];

  logic [c_CNT_W:0]   w_inflight;
  logic               w_grant;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [c_CNT_W-1:0] w_out_next;
  logic [ADDR_W-1:0]  w_redirect_pc;
  logic               w_unused_rpc_lsb;

  assign w_inflight    = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req      = !reset && !redirect_valid && (w_inflight < c_DEPTH_EXT);
  assign imem_addr     = r_fetch_pc;
  assign w_grant       = imem_req && imem_gnt;
  assign inst_valid    = (r_count != '0);
  assign w_pop         = inst_valid && inst_ready;
  assign w_drop        = imem_rvalid && (r_discard != '0);
  assign w_push        = imem_rvalid && (r_discard == '0);
  assign inst          = r_inst_mem[r_rptr];
  assign inst_pc       = r_pc_mem[r_rptr];
  assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused_rpc_lsb = ^redirect_pc[1:0];

  // Stale responses remain outstanding until they return; discard tracks how many to drop.
  assign w_out_next = r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(imem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_count       <= '0;
      r_outstanding <= w_out_next;
      r_discard     <= w_out_next;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_discard     <= r_discard - c_CNT_W'(w_drop);
      r_count       <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + ADDR_W'(4);
        r_wptr    <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && w_push) begin
      r_inst_mem[r_wptr] <= imem_rdata;
      r_pc_mem[r_wptr]   <= r_resp_pc;
    end
  end

  property p_credit;
    @(posedge clk) disable iff (reset) (w_inflight <= c_DEPTH_EXT);
  endproperty
  a_credit: assert property (p_credit);

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_buffer.sv
// +--------------------------------------------------------------------------+
// | tb_inst_fetch_buffer: randomized bench with an epoch-tagged queue model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_inst_fetch_buffer;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt = 1'b0;
  logic              imem_rvalid = 1'b0;
  logic [INST_W-1:0] imem_rdata = '0;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;

  inst_fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .DEPTH   (DEPTH),
    .RESET_PC(64'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
    int          dcyc;
    logic [31:0] obs_inst;
    logic [63:0] obs_pc;
  } entry_t;

  entry_t      mq[$];        // requests held by the memory model
  entry_t      rq[$];        // instructions expected in the buffer
  entry_t      delivered[$]; // instructions handed to decode
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          n_grants = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          known = 0;
  logic [63:0] m_fetch = '0;

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit rst, input bit redir, input logic [63:0] rpc,
                      input bit rdy, input bit gnt);
    entry_t      e;
    logic [63:0] tmp;
    bit          exp_req;
    @(negedge clk);
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    imem_gnt       = gnt;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      tmp         = mq[0].addr >> 2;
      imem_rdata  = tmp[31:0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    if (known) begin
      exp_req = !rst && !redir && ((rq.size() + mq.size()) < DEPTH);
      n_total++;
      if (imem_req !== exp_req) $display("FAIL imem_req cyc=%0d got=%0b exp=%0b", cyc, imem_req, exp_req);
      else n_pass++;
      n_total++;
      if (imem_addr !== m_fetch) $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fetch);
      else n_pass++;
      n_total++;
      if (inst_valid !== (rq.size() != 0)) $display("FAIL inst_valid cyc=%0d got=%0b exp=%0b", cyc, inst_valid, rq.size() != 0);
      else n_pass++;
      if (rq.size() != 0) begin
        tmp = rq[0].addr >> 2;
        n_total++;
        if (inst !== tmp[31:0]) $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst, tmp[31:0]);
        else n_pass++;
        n_total++;
        if (inst_pc !== rq[0].addr) $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, rq[0].addr);
        else n_pass++;
      end
    end
    if (rst) begin
      rq.delete();
      mq.delete();
      m_fetch = 64'h0;
      epoch++;
      known = 1;
    end else if (redir) begin
      rq.delete();
      if (imem_rvalid) void'(mq.pop_front());
      m_fetch = {rpc[63:2], 2'b00};
      epoch++;
    end else begin
      if (inst_valid && rdy && rq.size() > 0) begin
        e          = rq.pop_front();
        e.dcyc     = cyc;
        e.obs_inst = inst;
        e.obs_pc   = inst_pc;
        delivered.push_back(e);
      end
      if (imem_rvalid) begin
        e = mq.pop_front();
        if (e.epoch == epoch) rq.push_back(e);
      end
      if (imem_req && gnt) begin
        e.addr  = imem_addr;
        e.epoch = epoch;
        e.due   = cyc + lat;
        mq.push_back(e);
        m_fetch = m_fetch + 64'd4;
        n_grants++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 64'h0, 1, 1);
    delivered.delete();
    n_grants = 0;
  endtask

  task automatic test_reset();
    lat = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 64'h0, 0, 1);
    step(0, 0, 64'h0, 0, 0);
    n_total++;
    if (imem_req !== 1'b1) $display("FAIL t1_req got=%0b exp=1", imem_req); else n_pass++;
    n_total++;
    if (imem_addr !== 64'h0) $display("FAIL t1_addr got=%h exp=0", imem_addr); else n_pass++;
    n_total++;
    if (inst_valid !== 1'b0) $display("FAIL t1_valid got=%0b exp=0", inst_valid); else n_pass++;
  endtask

  task automatic test_stream();
    lat = 1;
    do_reset();
    for (int k = 0; k < 200 && delivered.size() < 64; k++) step(0, 0, 64'h0, 1, 1);
    n_total++;
    if (delivered.size() < 64) $display("FAIL t2_timeout got=%0d exp=64", delivered.size());
    else begin
      n_pass++;
      for (int i = 0; i < 64; i++) begin
        n_total++;
        if (delivered[i].obs_inst !== 32'(i) || delivered[i].obs_pc !== 64'(4 * i))
          $display("FAIL t2_order i=%0d got=%h/%h exp=%h/%h", i, delivered[i].obs_inst, delivered[i].obs_pc, i, 4 * i);
        else n_pass++;
      end
      n_total++;
      if (delivered[63].dcyc - delivered[0].dcyc != 63)
        $display("FAIL t2_gaps got=%0d exp=63", delivered[63].dcyc - delivered[0].dcyc);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    lat = 1;
    do_reset();
    for (int k = 0; k < 10; k++) step(0, 0, 64'h0, 0, 1);
    n_total++;
    if (n_grants != 4) $display("FAIL t3_grants got=%0d exp=4", n_grants); else n_pass++;
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL t3_req got=%0b exp=0", imem_req); else n_pass++;
    n_total++;
    if (inst_valid !== 1'b1 || inst !== 32'h0) $display("FAIL t3_head got=%0b/%h exp=1/0", inst_valid, inst);
    else n_pass++;
    for (int k = 0; k < 40 && delivered.size() < 8; k++) step(0, 0, 64'h0, 1, 1);
    n_total++;
    if (delivered.size() < 8) $display("FAIL t3_timeout got=%0d exp=8", delivered.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (delivered[i].obs_inst !== 32'(i)) $display("FAIL t3_order i=%0d got=%h exp=%h", i, delivered[i].obs_inst, i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_redirect_discard();
    lat = 3;
    do_reset();
    step(0, 0, 64'h0, 1, 1);
    step(0, 0, 64'h0, 1, 1);
    step(0, 1, 64'h103, 1, 1);
    for (int k = 0; k < 30 && delivered.size() < 2; k++) step(0, 0, 64'h0, 1, 1);
    n_total++;
    if (delivered.size() < 2) $display("FAIL t4_timeout got=%0d exp=2", delivered.size());
    else begin
      n_pass++;
      n_total++;
      if (delivered[0].obs_inst !== 32'h40 || delivered[0].obs_pc !== 64'h100)
        $display("FAIL t4_first got=%h/%h exp=40/100", delivered[0].obs_inst, delivered[0].obs_pc);
      else n_pass++;
      n_total++;
      if (delivered[1].obs_inst !== 32'h41 || delivered[1].obs_pc !== 64'h104)
        $display("FAIL t4_second got=%h/%h exp=41/104", delivered[1].obs_inst, delivered[1].obs_pc);
      else n_pass++;
    end
  endtask

  task automatic test_gnt_stall();
    lat = 1;
    do_reset();
    for (int k = 0; k < 30 && m_fetch != 64'h20; k++) step(0, 0, 64'h0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 64'h0, 1, 0);
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h20)
        $display("FAIL t5_hold k=%0d got=%0b/%h exp=1/20", k, imem_req, imem_addr);
      else n_pass++;
    end
    for (int k = 0; k < 60 && delivered.size() < 16; k++) step(0, 0, 64'h0, 1, 1);
    n_total++;
    if (delivered.size() < 16) $display("FAIL t5_timeout got=%0d exp=16", delivered.size());
    else begin
      n_pass++;
      for (int i = 0; i < 16; i++) begin
        n_total++;
        if (delivered[i].obs_inst !== 32'(i)) $display("FAIL t5_order i=%0d got=%h exp=%h", i, delivered[i].obs_inst, i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    lat = 2;
    do_reset();
    for (int k = 0; k < 6; k++) step(0, 0, 64'h0, 1, 1);
    for (int k = 0; k < 20 && !(rq.size() > 0 && mq.size() > 0 && mq[0].due <= cyc); k++)
      step(0, 0, 64'h0, 1, 1);
    step(0, 1, 64'h200, 1, 1);
    step(0, 1, 64'h301, 1, 1);
    delivered.delete();
    for (int k = 0; k < 40 && delivered.size() < 4; k++) step(0, 0, 64'h0, 1, 1);
    n_total++;
    if (delivered.size() < 4) $display("FAIL t6_timeout got=%0d exp=4", delivered.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (delivered[i].obs_pc !== 64'h300 + 64'(4 * i) || delivered[i].obs_inst !== 32'hC0 + 32'(i))
          $display("FAIL t6_target i=%0d got=%h/%h exp=%h/%h", i, delivered[i].obs_pc, delivered[i].obs_inst,
                   64'h300 + 64'(4 * i), 32'hC0 + 32'(i));
        else n_pass++;
      end
    end
    for (int k = 0; k < 5; k++) step(0, 0, 64'h0, 1, 1);
    step(1, 0, 64'h0, 1, 1);
    step(0, 0, 64'h0, 1, 1);
    n_total++;
    if (inst_valid !== 1'b0 || imem_addr !== 64'h0 || imem_req !== 1'b1)
      $display("FAIL t6_reset got=%0b/%h/%0b exp=0/0/1", inst_valid, imem_addr, imem_req);
    else n_pass++;
  endtask

  task automatic test_random();
    bit          gnt;
    bit          rdy;
    bit          redir;
    logic [63:0] rpc;
    for (int run = 0; run < 3; run++) begin
      lat = $urandom_range(1, 4);
      do_reset();
      for (int k = 0; k < 400; k++) begin
        gnt   = ($urandom % 4) != 0;
        rdy   = ($urandom % 3) != 0;
        redir = ($urandom % 20) == 0;
        if (($urandom % 4) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
        else rpc = {$urandom, $urandom};
        step(0, redir, rpc, rdy, gnt);
      end
      n_total++;
      if (delivered.size() == 0) $display("FAIL rnd_progress run=%0d got=0 exp=>0", run);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_gnt_stall();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
